// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side bundle shared by the ALU arbiter and its environment.
// master: requesters plus the ALU; slave: the arbiter itself.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  // Requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_q;
  logic [2:0]        rsp0_flags;
  logic              rsp0_err;

  // Requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_q;
  logic [2:0]        rsp1_flags;
  logic              rsp1_err;

  // Shared combinational ALU
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_q;
  logic              alu_zero;
  logic              alu_neg;
  logic              alu_ovf;

  logic              busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    output alu_q, alu_zero, alu_neg, alu_ovf,
    input  req0_ready, rsp0_valid, rsp0_q, rsp0_flags, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_q, rsp1_flags, rsp1_err,
    input  alu_a, alu_b, alu_op, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    input  alu_q, alu_zero, alu_neg, alu_ovf,
    output req0_ready, rsp0_valid, rsp0_q, rsp0_flags, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_q, rsp1_flags, rsp1_err,
    output alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each accepted operation runs IDLE -> EXEC -> RESP and is returned on its owner's response channel.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [OP_W-1:0] MAX_OP = OP_W'(9);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q,  prio_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] a_q,     a_d;
  logic [DATA_W-1:0] b_q,     b_d;
  logic [OP_W-1:0]   op_q,    op_d;
  logic [DATA_W-1:0] res_q,   res_d;
  logic [2:0]        flags_q, flags_d;
  logic              err_q,   err_d;

  logic req_any;
  logic grant;
  logic accept;
  logic rsp_ack;

  // Grant goes to the lone valid requester, or to the favoured one on a tie.
  always_comb begin
    req_any = bus.req0_valid | bus.req1_valid;
    grant   = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
    accept  = (state_q == IDLE) && req_any;
    rsp_ack = (state_q == RESP) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = grant ? bus.req1_a  : bus.req0_a;
          b_d     = grant ? bus.req1_b  : bus.req0_b;
          op_d    = grant ? bus.req1_op : bus.req0_op;
          owner_d = grant;
          prio_d  = ~grant;
          state_d = EXEC;
        end
      end

      EXEC: begin
        // Opcodes beyond SLTU have no defined ALU result, so report an error with cleared data.
        if (op_q > MAX_OP) begin
          res_d   = '0;
          flags_d = 3'b000;
          err_d   = 1'b1;
        end else begin
          res_d   = bus.alu_q;
          flags_d = {bus.alu_ovf, bus.alu_neg, bus.alu_zero};
          err_d   = 1'b0;
        end
        state_d = RESP;
      end

      RESP: begin
        if (rsp_ack) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign bus.req0_ready = rst_n && accept && !grant;
  assign bus.req1_ready = rst_n && accept &&  grant;

  assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == RESP) &&  owner_q;

  assign bus.rsp0_q     = res_q;
  assign bus.rsp1_q     = res_q;
  assign bus.rsp0_flags = flags_q;
  assign bus.rsp1_flags = flags_q;
  assign bus.rsp0_err   = err_q;
  assign bus.rsp1_err   = err_q;

  assign bus.alu_a  = a_q;
  assign bus.alu_b  = b_q;
  assign bus.alu_op = op_q;

  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model and a behavioural ALU.
module tb_alu_arbiter;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic m_prio;

  alu_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: signed-range overflow, garbage result for undefined opcodes.
  function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic ovf);
    longint s;
    ovf = 1'b0;
    q   = 32'h0;
    case (op)
      OP_ADD:  begin s = longint'($signed(a)) + longint'($signed(b)); q = s[31:0];
                     ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_SUB:  begin s = longint'($signed(a)) - longint'($signed(b)); q = s[31:0];
                     ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_AND:  q = a & b;
      OP_OR:   q = a | b;
      OP_XOR:  q = a ^ b;
      OP_SLL:  q = a << b[4:0];
      OP_SRL:  q = a >> b[4:0];
      OP_SRA:  q = $signed(a) >>> b[4:0];
      OP_SLT:  q = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: q = (a < b) ? 32'd1 : 32'd0;
      default: begin q = 32'hDEAD_BEEF; ovf = 1'b1; end
    endcase
  endfunction

  always_comb begin
    logic [31:0] q;
    logic        ovf;
    alu_ref(bus.alu_op, bus.alu_a, bus.alu_b, q, ovf);
    bus.alu_q    = q;
    bus.alu_ovf  = ovf;
    bus.alu_neg  = q[31];
    bus.alu_zero = (q == 32'h0);
  end

  // Expected response for a request: error with cleared data for opcodes above 9.
  function automatic void expect_rsp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] q, output logic [2:0] flags, output logic err);
    logic ovf;
    if (op > 4'd9) begin
      q = 32'h0; flags = 3'b000; err = 1'b1;
    end else begin
      alu_ref(op, a, b, q, ovf);
      flags = {ovf, q[31], q == 32'h0};
      err   = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},       64'(bus.busy),       64'd0);
    check({tag, " req0_ready"}, 64'(bus.req0_ready), 64'd0);
    check({tag, " req1_ready"}, 64'(bus.req1_ready), 64'd0);
    check({tag, " rsp0_valid"}, 64'(bus.rsp0_valid), 64'd0);
    check({tag, " rsp1_valid"}, 64'(bus.rsp1_valid), 64'd0);
    check({tag, " rsp0_q"},     64'(bus.rsp0_q),     64'd0);
    check({tag, " rsp1_q"},     64'(bus.rsp1_q),     64'd0);
    check({tag, " rsp_flags"},  64'({bus.rsp0_flags, bus.rsp1_flags}), 64'd0);
    check({tag, " rsp_err"},    64'({bus.rsp0_err, bus.rsp1_err}),     64'd0);
    check({tag, " alu_a"},      64'(bus.alu_a),      64'd0);
    check({tag, " alu_b"},      64'(bus.alu_b),      64'd0);
    check({tag, " alu_op"},     64'(bus.alu_op),     64'd0);
  endtask

  // One full transaction starting in IDLE at posedge+1; hold = cycles rsp_ready stays low in RESP.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        input int hold);
    logic        g;
    logic [3:0]  eop;
    logic [31:0] ea, eb, eq;
    logic [2:0]  ef;
    logic        ee;
    logic        own_rv, oth_rv;

    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    #1;
    g = (v0 && v1) ? m_prio : v1;
    check("req0_ready grant", 64'(bus.req0_ready), 64'(!g));
    check("req1_ready grant", 64'(bus.req1_ready), 64'(g));
    tick();

    // EXEC: operands of the granted requester must reach the ALU.
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    m_prio = ~g;
    eop = g ? op1 : op0;
    ea  = g ? a1  : a0;
    eb  = g ? b1  : b0;
    expect_rsp(eop, ea, eb, eq, ef, ee);
    check("exec busy",  64'(bus.busy),   64'd1);
    check("exec alu_a", 64'(bus.alu_a),  64'(ea));
    check("exec alu_b", 64'(bus.alu_b),  64'(eb));
    check("exec alu_op",64'(bus.alu_op), 64'(eop));
    check("exec rsp_valid", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
    tick();

    for (int i = 0; i <= hold; i++) begin
      if (g) begin
        bus.rsp1_ready = (i == hold); bus.rsp0_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.rsp0_ready = (i == hold); bus.rsp1_ready = 1'($urandom_range(0, 1));
      end
      bus.req0_valid = (i < hold);
      bus.req1_valid = (i < hold);
      #1;
      own_rv = g ? bus.rsp1_valid : bus.rsp0_valid;
      oth_rv = g ? bus.rsp0_valid : bus.rsp1_valid;
      check("resp owner valid", 64'(own_rv), 64'd1);
      check("resp other valid", 64'(oth_rv), 64'd0);
      check("resp q",     64'(g ? bus.rsp1_q     : bus.rsp0_q),     64'(eq));
      check("resp flags", 64'(g ? bus.rsp1_flags : bus.rsp0_flags), 64'(ef));
      check("resp err",   64'(g ? bus.rsp1_err   : bus.rsp0_err),   64'(ee));
      check("resp busy",  64'(bus.busy), 64'd1);
      if (i < hold)
        check("resp req_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
      tick();
    end

    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1;
    check("idle busy", 64'(bus.busy), 64'd0);
    check("idle rsp_valid", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        v0, v1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    int          pat;

    checks = 0; errors = 0; m_prio = 1'b0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0; bus.rsp0_ready = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0; bus.rsp1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Fairness: simultaneous pairs go 0, 1, 0.
    run_op(1, 1, OP_SUB, 32'd20, 32'd5, OP_AND, 32'd12, 32'd5, 0);
    run_op(1, 1, OP_SUB, 32'd20, 32'd5, OP_AND, 32'd12, 32'd5, 0);
    run_op(1, 1, OP_ADD, 32'd7,  32'd9, OP_OR,  32'd3,  32'd8, 0);

    // Directed single-requester cases.
    run_op(1, 0, OP_ADD, 32'd15, 32'd10, 4'd0, 32'd0, 32'd0, 0);
    run_op(0, 1, 4'd0, 32'd0, 32'd0, OP_SRA, 32'hFFFF_FFF8, 32'd2, 5);
    run_op(1, 0, 4'd12, 32'd3, 32'd4, 4'd0, 32'd0, 32'd0, 0);
    run_op(1, 0, OP_SUB, 32'd5, 32'd5, 4'd0, 32'd0, 32'd0, 0);
    run_op(1, 0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 4'd0, 32'd0, 32'd0, 1);

    // Reset during EXEC drops the request.
    bus.req0_valid = 1'b1; bus.req0_op = OP_SLT; bus.req0_a = 32'hFFFF_FFFB; bus.req0_b = 32'd3;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid reset");
    tick();
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    m_prio = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post reset rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
      check("post reset busy",       64'(bus.busy),       64'd0);
      tick();
    end
    run_op(0, 1, 4'd0, 32'd0, 32'd0, OP_ADD, 32'd1, 32'd1, 0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      pat = $urandom_range(1, 3);
      v0  = pat[0];
      v1  = pat[1];
      op0 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      op1 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      a0  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b0  = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      a1  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      b1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run_op(v0, v1, op0, a0, b0, op1, a1, b1, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters, such as the execute stage and the branch-compare path, using round-robin arbitration. Each requester issues an operation over a valid/ready handshake, and the arbiter registers the operands and drives them into the ALU for one cycle. It then captures the result and flags and returns them on that requester's response channel, holding them until accepted. The block sits between the pipeline front-ends and the `alu` instance and owns the ALU's `A`/`B`/`Opcode` inputs.

## Interface
- `DATA_W`, 32, operand/result width
- `OP_W`, 4, opcode width; legal opcodes are 0..9 (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU)

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req0_valid` / `req1_valid` in 1: request valid
- `req0_ready` / `req1_ready` out 1: request accepted this cycle when valid and ready are both high
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in DATA_W: operands
- `req0_op` / `req1_op` in OP_W: opcode
- `rsp0_valid` / `rsp1_valid` out 1: response valid
- `rsp0_ready` / `rsp1_ready` in 1: response consumed
- `rsp0_q` / `rsp1_q` out DATA_W: result
- `rsp0_flags` / `rsp1_flags` out 3: {Overflow, Neg, Zero}
- `rsp0_err` / `rsp1_err` out 1: illegal opcode
- `alu_a`, `alu_b` out DATA_W; `alu_op` out OP_W: drive the ALU's `A`, `B`, `Opcode`
- `alu_q` in DATA_W; `alu_zero`, `alu_neg`, `alu_ovf` in 1: from the ALU's `Q`, `Zero`, `Neg`, `Overflow`
- `busy` out 1: high whenever state ≠ IDLE

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **Priority pointer:** 1 bit, `prio`; reset value 0, meaning requester 0 is favoured.
- **Grant in IDLE:**
  - If only one requester is valid, grant it.
  - If both are valid, grant requester `prio`.
  - `reqX_ready = (state==IDLE) && grant==X`. Ready is combinational from the valid inputs and is never high for both requesters at once.
- **On accept** (IDLE → EXEC):
  - Latch a, b, op into operand registers.
  - Latch the owner id.
  - Set `prio` to the requester not granted.
- **`alu_a`/`alu_b`/`alu_op`:** always driven from the operand registers. They hold their value outside EXEC.
- **EXEC** (→ RESP, unconditionally after one cycle): register `alu_q` and the three flags into the response register.
  - If op > 9: force q = 0, flags = 000, err = 1.
  - Otherwise err = 0.
- **RESP:**
  - Assert `rspX_valid` for the owner only. The other `rsp_valid` stays 0.
  - q, flags and err are held stable until `rspX_ready`.
  - On a handshake, go to IDLE.
  - A new request is never accepted in RESP, so the response channel cannot be overrun.
- **`rsp*_q/flags/err` outputs:** come from the single shared response register. They are meaningful only while the corresponding valid is high.
- **Invalid request:** a requester that drops valid before being granted is simply not served.

## Timing
- **Reset:** all outputs 0, state IDLE, `prio` 0, operand and response registers 0.
- **Reset mid-operation:** asynchronous clear of all state. An in-flight request is dropped and no response is issued.
- **Latency:**
  - Accept at cycle N.
  - ALU driven during N+1.
  - `rspX_valid` high from N+2.
- **Throughput:** minimum 3 cycles per operation, with `rsp_ready` held high.
- **Backpressure:** with `rsp_ready` low, the block stays in RESP indefinitely, `busy` stays 1, and both `req_ready` stay 0.
- **Requests during RESP:** a request arriving in the same cycle as a RESP handshake is accepted at the earliest in the following (IDLE) cycle.
- **Fairness:** with both requesters continuously valid, grants alternate 0, 1, 0, 1, …

## Test plan
- req0 ADD a=15, b=10 at cycle N, rsp0_ready high → req0_ready=1 at N; rsp0_valid at N+2 with q=25, flags=000, err=0; rsp1_valid stays 0.
- Both requests valid after reset: req0 SUB 20−5, req1 AND 12&5 → req0 granted first (q=15). req1 is granted on the next IDLE (q=4). Then a third simultaneous pair is granted to req0 again.
- req1 SRA a=−8, b=2, with rsp1_ready held low for 5 cycles → rsp1_q=0xFFFFFFFE, flags=010, held stable. busy=1 and both req_ready=0 throughout. Completes when ready rises.
- req0 op=4'd12 → rsp0_err=1, q=0, flags=000, latency 2.
- req0 SLT a=−5, b=3, then rst_n pulsed low during EXEC → all outputs 0 asynchronously, no rsp0_valid after release. A fresh req1 ADD 1+1 completes with q=2.
- req0 SUB 5−5 → q=0, flags=001 (Zero set).
